// File: rtl/line_buffer_7x7.sv
// Row-alignment stage for a 7x7 window: keeps the six previous image rows and
// emits one vertically aligned 7-pixel column per accepted raster-scan pixel.
module line_buffer_7x7 #(
   parameter int COLS = 9,
   parameter int ROWS = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic [7:0] S1_o,
   output logic [7:0] S2_o,
   output logic [7:0] S3_o,
   output logic [7:0] S4_o,
   output logic [7:0] S5_o,
   output logic [7:0] S6_o,
   output logic [7:0] S7_o,
   output logic       valid_o,
   output logic       row_start_o,
   output logic       frame_done_o
);

   localparam int AW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DEPTH = 1 << AW;
   localparam logic [9:0] LAST_COL      = 10'(COLS - 1);
   localparam logic [9:0] LAST_ROW      = 10'(ROWS - 1);
   localparam logic [9:0] LAST_FILL_ROW = 10'd5;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [9:0]      col_cnt_r;
   logic [9:0]      row_cnt_r;
   logic [AW-1:0]   col_addr_s;
   logic            last_col_s;
   logic            last_row_s;
   logic            stream_px_s;
   logic [7:0]      row_mem_r [6][DEPTH];
   logic [7:0]      col_r [7];
   logic            valid_r;
   logic            row_start_r;
   logic            frame_done_r;

   assign col_addr_s = col_cnt_r[AW-1:0];
   assign last_col_s = (col_cnt_r == LAST_COL);
   assign last_row_s = (row_cnt_r == LAST_ROW);

   // Raster position counters; both wrap together on the last pixel of a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt_r <= 10'd0;
         row_cnt_r <= 10'd0;
      end else if (valid_i) begin
         if (last_col_s) begin
            col_cnt_r <= 10'd0;
            row_cnt_r <= last_row_s ? 10'd0 : (row_cnt_r + 10'd1);
         end else begin
            col_cnt_r <= col_cnt_r + 10'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= FILL;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next state and the per-pixel "column is complete" qualifier.
   always_comb begin
      next_state_s = state_r;
      stream_px_s  = 1'b0;
      case (state_r)
         FILL: begin
            if (valid_i && last_col_s && (row_cnt_r == LAST_FILL_ROW)) begin
               next_state_s = STREAM;
            end else begin
               next_state_s = FILL;
            end
         end
         STREAM: begin
            stream_px_s = valid_i;
            if (valid_i && last_col_s && last_row_s) begin
               next_state_s = FILL;
            end else begin
               next_state_s = STREAM;
            end
         end
         default: begin
            next_state_s = FILL;
            stream_px_s  = 1'b0;
         end
      endcase
   end

   // Row shift chain: each row takes the younger row's pixel at the shared column.
   always_ff @(posedge clk) begin
      if (valid_i) begin
         for (int k = 0; k < 5; k++) begin
            row_mem_r[k][col_addr_s] <= row_mem_r[k+1][col_addr_s];
         end
         row_mem_r[5][col_addr_s] <= data_i;
      end
   end

   // Output column and flags; reads see pre-write contents, so no write-through.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 7; k++) begin
            col_r[k] <= 8'd0;
         end
         valid_r      <= 1'b0;
         row_start_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         valid_r      <= stream_px_s;
         row_start_r  <= stream_px_s && (col_cnt_r == 10'd0);
         frame_done_r <= stream_px_s && last_col_s && last_row_s;
         if (valid_i) begin
            for (int k = 0; k < 6; k++) begin
               col_r[k] <= row_mem_r[k][col_addr_s];
            end
            col_r[6] <= data_i;
         end
      end
   end

   assign S1_o         = col_r[0];
   assign S2_o         = col_r[1];
   assign S3_o         = col_r[2];
   assign S4_o         = col_r[3];
   assign S5_o         = col_r[4];
   assign S6_o         = col_r[5];
   assign S7_o         = col_r[6];
   assign valid_o      = valid_r;
   assign row_start_o  = row_start_r;
   assign frame_done_o = frame_done_r;

endmodule

// File: tb/tb_line_buffer_7x7.sv
// Scoreboard bench for line_buffer_7x7: a 9x9 instance and a minimum-size 7x7
// instance, with expected columns queued at stimulus time and checked by a monitor.
module tb_line_buffer_7x7;

   typedef struct packed {
      logic [6:0][7:0] s;
      logic            rs;
      logic            fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       vi [2];
   logic [7:0] di [2];
   logic [7:0] o_s [2][7];
   logic       vo [2];
   logic       rs [2];
   logic       fd [2];

   exp_t       q [2][$];
   int         tests = 0;
   int         failed = 0;
   int         vcnt [2] = '{0, 0};
   int         fdcnt [2] = '{0, 0};
   int         fd_at [2] = '{0, 0};
   int         phase [2] = '{0, 0};
   int         got_phase [2] = '{0, 0};
   int         acc [2] = '{0, 0};
   int         first_acc [2] = '{0, 0};
   logic [55:0] first_col [2];
   logic [55:0] fd_col [2];
   logic [55:0] post_col [2];
   logic [55:0] prev_s [2];
   logic       post_pend [2] = '{1'b0, 1'b0};
   logic       last_vi [2] = '{1'b0, 1'b0};
   logic       last_rst = 1'b1;
   logic       have_prev = 1'b0;

   always #5 clk = ~clk;

   line_buffer_7x7 #(.COLS(9), .ROWS(9)) dut9 (
      .clk(clk), .rst(rst), .valid_i(vi[0]), .data_i(di[0]),
      .S1_o(o_s[0][0]), .S2_o(o_s[0][1]), .S3_o(o_s[0][2]), .S4_o(o_s[0][3]),
      .S5_o(o_s[0][4]), .S6_o(o_s[0][5]), .S7_o(o_s[0][6]),
      .valid_o(vo[0]), .row_start_o(rs[0]), .frame_done_o(fd[0])
   );

   line_buffer_7x7 #(.COLS(7), .ROWS(7)) dut7 (
      .clk(clk), .rst(rst), .valid_i(vi[1]), .data_i(di[1]),
      .S1_o(o_s[1][0]), .S2_o(o_s[1][1]), .S3_o(o_s[1][2]), .S4_o(o_s[1][3]),
      .S5_o(o_s[1][4]), .S6_o(o_s[1][5]), .S7_o(o_s[1][6]),
      .valid_o(vo[1]), .row_start_o(rs[1]), .frame_done_o(fd[1])
   );

   function automatic logic [55:0] pack(int d);
      return {o_s[d][6], o_s[d][5], o_s[d][4], o_s[d][3], o_s[d][2], o_s[d][1], o_s[d][0]};
   endfunction

   function automatic logic [7:0] f(int mode, int r, int c);
      case (mode)
         0:       return 8'(16 * r + c);
         1:       return 8'(240 + c);
         default: return 8'(7 * r + c);
      endcase
   endfunction

   task automatic chk(string name, int d, logic [63:0] act, logic [63:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, d, act, req, $time);
      end
   endtask

   // Accepted-pixel count and previous-cycle inputs, as the DUT saw them.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         last_vi[d] <= vi[d];
         if (vi[d]) acc[d] <= acc[d] + 1;
      end
      last_rst <= rst;
   end

   // Monitor: pop and compare on every valid column; check gaps hold outputs.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (vo[d]) begin
            if (q[d].size() == 0) begin
               chk("unexpected_valid", d, 64'd1, 64'd0);
            end else begin
               chk("column", d, pack(d), q[d][0].s);
               chk("row_start", d, rs[d], q[d][0].rs);
               chk("frame_done", d, fd[d], q[d][0].fd);
               void'(q[d].pop_front());
            end
            vcnt[d] <= vcnt[d] + 1;
            if (got_phase[d] != phase[d]) begin
               got_phase[d] <= phase[d];
               first_col[d] <= pack(d);
               first_acc[d] <= acc[d];
            end
            if (post_pend[d]) begin
               post_col[d]  <= pack(d);
               post_pend[d] <= 1'b0;
            end
            if (fd[d]) begin
               fdcnt[d]     <= fdcnt[d] + 1;
               fd_at[d]     <= vcnt[d] + 1;
               fd_col[d]    <= pack(d);
               post_pend[d] <= 1'b1;
            end
         end else begin
            chk("idle_flags", d, {rs[d], fd[d]}, 2'b00);
         end
         if (have_prev && !last_vi[d] && !last_rst)
            chk("hold_in_gap", d, {vo[d], pack(d)}, {1'b0, prev_s[d]});
         prev_s[d] <= pack(d);
      end
      have_prev <= 1'b1;
   end

   task automatic idle();
      vi[0] = 1'b0;
      vi[1] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(int d, int mode, int r, int c, int rows, int cols);
      exp_t e;
      if (r >= 6) begin
         for (int j = 0; j < 7; j++) e.s[j] = f(mode, r - 6 + j, c);
         e.rs = (c == 0);
         e.fd = (r == rows - 1) && (c == cols - 1);
         q[d].push_back(e);
      end
      vi[d]     = 1'b1;
      vi[1 - d] = 1'b0;
      di[d]     = f(mode, r, c);
      @(posedge clk);
      #1;
      vi[d] = 1'b0;
   endtask

   task automatic frame(int d, int mode, int rows, int cols, bit toggle, int npix);
      int n = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            if (n < npix) begin
               pixel(d, mode, r, c, rows, cols);
               if (toggle) idle();
            end
            n++;
         end
      end
   endtask

   task automatic check_reset(string name);
      for (int d = 0; d < 2; d++)
         chk(name, d, {pack(d), vo[d], rs[d], fd[d]}, 64'd0);
   endtask

   initial begin
      int vb, fb, ab;
      rst   = 1'b1;
      vi[0] = 1'b0; vi[1] = 1'b0;
      di[0] = 8'd0; di[1] = 8'd0;
      idle();
      idle();
      check_reset("reset_state");
      rst = 1'b0;

      // Ramp frame, continuous valid.
      phase[0]++; vb = vcnt[0]; fb = fdcnt[0];
      frame(0, 0, 9, 9, 1'b0, 81);
      idle();
      chk("t1_valid_count", 0, vcnt[0] - vb, 64'd27);
      chk("t1_frame_done_count", 0, fdcnt[0] - fb, 64'd1);
      chk("t1_fd_on_last_col", 0, fd_at[0] - vb, 64'd27);
      chk("t1_first_col", 0, first_col[0], 56'h60504030201000);
      chk("t1_fd_S1", 0, fd_col[0][7:0], 8'h28);
      chk("t1_fd_S7", 0, fd_col[0][55:48], 8'h88);

      // Same frame with valid toggling every cycle.
      phase[0]++; vb = vcnt[0]; fb = fdcnt[0];
      frame(0, 0, 9, 9, 1'b1, 81);
      idle();
      chk("t2_valid_count", 0, vcnt[0] - vb, 64'd27);
      chk("t2_frame_done_count", 0, fdcnt[0] - fb, 64'd1);
      chk("t2_first_col", 0, first_col[0], 56'h60504030201000);

      // Two frames back-to-back; second frame is 0xF0+c in every row.
      phase[0]++; vb = vcnt[0]; fb = fdcnt[0];
      frame(0, 0, 9, 9, 1'b0, 81);
      frame(0, 1, 9, 9, 1'b0, 81);
      idle();
      chk("t3_valid_count", 0, vcnt[0] - vb, 64'd54);
      chk("t3_frame_done_count", 0, fdcnt[0] - fb, 64'd2);
      chk("t3_second_first_col", 0, post_col[0], 56'hF0F0F0F0F0F0F0);

      // Reset in the middle of row 7, then a fresh frame.
      frame(0, 0, 9, 9, 1'b0, 67);
      rst = 1'b1;
      idle();
      check_reset("t4_reset_mid_frame");
      rst = 1'b0;
      phase[0]++; vb = vcnt[0]; ab = acc[0];
      frame(0, 0, 9, 9, 1'b0, 81);
      idle();
      chk("t4_first_valid_pixel", 0, first_acc[0] - ab, 64'd55);
      chk("t4_valid_count", 0, vcnt[0] - vb, 64'd27);
      chk("t4_first_col", 0, first_col[0], 56'h60504030201000);

      // Minimum 7x7 frame, ramp 0..48.
      phase[1]++; vb = vcnt[1]; fb = fdcnt[1];
      frame(1, 2, 7, 7, 1'b0, 49);
      idle();
      chk("t5_valid_count", 1, vcnt[1] - vb, 64'd7);
      chk("t5_frame_done_count", 1, fdcnt[1] - fb, 64'd1);
      chk("t5_fd_on_7th", 1, fd_at[1] - vb, 64'd7);
      chk("t5_first_col", 1, first_col[1], 56'h2A231C150E0700);

      idle();
      chk("queues_drained", 0, q[0].size() + q[1].size(), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
